// File: rtl/ct_f_spsram_128x16_ctrl.sv
// Request-side controller for the 128x16 single-port SRAM: valid/ready reads and masked writes,
// 2-entry read response buffer, optional post-reset init sweep (CT_F_SPSRAM_CTRL_INIT_EN).
module ct_f_spsram_128x16_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 7,
  parameter int unsigned           DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_bmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  logic [1:0]            occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic [ADDR_WIDTH-1:0] last_a;
  logic [DATA_WIDTH-1:0] last_d;
  logic                  init_wr;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  acc;
  logic                  push;
  logic                  pop;
  logic [2:0]            level;

`ifdef CT_F_SPSRAM_CTRL_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && cnt == '1) state_nxt = ST_RUN;
  end

  // Sweep pins are held off while RST is high so the array is untouched during reset.
  assign init_wr   = (state == ST_INIT) && !RST;
  assign init_addr = cnt;
  assign init_done = (state == ST_RUN);
`else
  assign init_wr   = 1'b0;
  assign init_addr = '0;
  assign init_done = 1'b1;
`endif

  // Credit: reads already issued (buffered or in flight) minus this cycle's pop must leave room.
  assign rsp_vld   = (occ != 2'd0);
  assign rsp_rdata = head;
  assign pop       = rsp_vld && rsp_rdy;
  assign push      = inflight;
  assign level     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign req_rdy   = init_done && !RST && (level < 3'd2);
  assign acc       = req_vld && req_rdy;

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = last_a;
    sram_d    = last_d;
    if (init_wr) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_addr;
      sram_d    = INIT_VAL;
    end else if (acc) begin
      sram_cen = 1'b0;
      sram_a   = req_addr;
      if (req_wr) begin
        sram_gwen = 1'b0;
        sram_wen  = ~req_bmask;
        sram_d    = req_wdata;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      occ      <= '0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      last_a   <= '0;
      last_d   <= '0;
    end else begin
      inflight <= acc && !req_wr;
      last_a   <= sram_a;
      last_d   <= sram_d;
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= sram_q;
          else             tail <= sram_q;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= sram_q;
          end else begin
            head <= tail;
            tail <= sram_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
